// File: rtl/dmem_ctrl.sv
// Two-port round-robin front end for a word-only data memory.
// Adds sub-word loads with extension and sub-word stores by read-modify-write.
module dmem_ctrl #(
  parameter int DATA_LENGTH      = 32,
  parameter int DMEM_ADDR_LENGTH = 32,
  parameter int MEM_DEPTH        = 50
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    req,
  input  logic [1:0]                    we,
  input  logic [2*DMEM_ADDR_LENGTH-1:0] addr,
  input  logic [2*DATA_LENGTH-1:0]      wdata,
  input  logic [3:0]                    size,
  input  logic [1:0]                    uns,
  output logic [1:0]                    ack,
  output logic                          err,
  output logic [DATA_LENGTH-1:0]        rdata,
  output logic                          busy,
  output logic [DMEM_ADDR_LENGTH-1:0]   mem_addr,
  output logic [DATA_LENGTH-1:0]        mem_wdata,
  output logic                          mem_we,
  input  logic [DATA_LENGTH-1:0]        mem_rdata
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, MERGE, WR} state_t;

  state_t                        state, state_d;
  logic                          rr_last, rr_last_d;
  logic [1:0]                    ack_d;
  logic                          err_d;
  logic [DATA_LENGTH-1:0]        rdata_d;
  logic [DMEM_ADDR_LENGTH-1:0]   mem_addr_d;
  logic [DATA_LENGTH-1:0]        mem_wdata_d;
  logic                          mem_we_d;
  logic                          take;

  logic [1:0]                    elig;
  logic                          sel;
  logic                          sel_we;
  logic                          sel_uns;
  logic [1:0]                    sel_size;
  logic [DMEM_ADDR_LENGTH-1:0]   sel_addr;
  logic [DATA_LENGTH-1:0]        sel_wdata;

  logic                          op_port;
  logic                          op_we;
  logic                          op_uns;
  logic [1:0]                    op_size;
  logic [1:0]                    op_lo;
  logic [15:0]                   op_wdata;

  function automatic logic bad_access(input logic [1:0] sz,
                                      input logic [DMEM_ADDR_LENGTH-1:0] a);
    logic [DMEM_ADDR_LENGTH-1:0] widx;
    widx = a >> 2;
    bad_access = (sz == 2'b11) ||
                 (sz == SZ_H && a[0]) ||
                 (sz == SZ_W && a[1:0] != 2'b00) ||
                 (widx >= DMEM_ADDR_LENGTH'(MEM_DEPTH));
  endfunction

  function automatic logic [DATA_LENGTH-1:0] load_extend(input logic [DATA_LENGTH-1:0] w,
                                                         input logic [1:0] lo,
                                                         input logic [1:0] sz,
                                                         input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = w[{lo[1], 4'b0000} +: 16];
    case (sz)
      SZ_B:    load_extend = {{(DATA_LENGTH-8){b[7] & ~u}}, b};
      SZ_H:    load_extend = {{(DATA_LENGTH-16){h[15] & ~u}}, h};
      default: load_extend = w;
    endcase
  endfunction

  function automatic logic [DATA_LENGTH-1:0] store_merge(input logic [DATA_LENGTH-1:0] w,
                                                         input logic [1:0] lo,
                                                         input logic [1:0] sz,
                                                         input logic [15:0] wd);
    logic [DATA_LENGTH-1:0] m;
    m = w;
    if (sz == SZ_B) m[{lo, 3'b000} +: 8]    = wd[7:0];
    else            m[{lo[1], 4'b0000} +: 16] = wd[15:0];
    store_merge = m;
  endfunction

  // A port whose ack is still visible is not eligible, so a held req is not re-accepted.
  assign elig      = req & ~ack;
  assign sel       = (elig == 2'b11) ? ~rr_last : elig[1];
  assign sel_we    = we[sel];
  assign sel_uns   = uns[sel];
  assign sel_size  = sel ? size[3:2] : size[1:0];
  assign sel_addr  = sel ? addr[2*DMEM_ADDR_LENGTH-1:DMEM_ADDR_LENGTH] : addr[DMEM_ADDR_LENGTH-1:0];
  assign sel_wdata = sel ? wdata[2*DATA_LENGTH-1:DATA_LENGTH] : wdata[DATA_LENGTH-1:0];

  always_comb begin
    state_d     = state;
    rr_last_d   = rr_last;
    ack_d       = 2'b00;
    err_d       = 1'b0;
    rdata_d     = rdata;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_we_d    = 1'b0;
    take        = 1'b0;
    case (state)
      IDLE: begin
        if (|elig) begin
          take      = 1'b1;
          rr_last_d = sel;
          if (bad_access(sel_size, sel_addr)) begin
            ack_d[sel] = 1'b1;
            err_d      = 1'b1;
          end else begin
            mem_addr_d = {sel_addr[DMEM_ADDR_LENGTH-1:2], 2'b00};
            if (sel_we && sel_size == SZ_W) begin
              mem_wdata_d = sel_wdata;
              mem_we_d    = 1'b1;
              state_d     = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        if (op_we) begin
          mem_wdata_d = store_merge(mem_rdata, op_lo, op_size, op_wdata);
          mem_we_d    = 1'b1;
          state_d     = MERGE;
        end else begin
          rdata_d        = load_extend(mem_rdata, op_lo, op_size, op_uns);
          ack_d[op_port] = 1'b1;
          state_d        = IDLE;
        end
      end
      MERGE, WR: begin
        ack_d[op_port] = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      ack       <= 2'b00;
      err       <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      state     <= state_d;
      rr_last   <= rr_last_d;
      ack       <= ack_d;
      err       <= err_d;
      rdata     <= rdata_d;
      busy      <= (state_d != IDLE);
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_we    <= mem_we_d;
    end
  end

  // Granted request snapshot; later input changes are ignored until IDLE.
  always_ff @(posedge clk) begin
    if (take) begin
      op_port  <= sel;
      op_we    <= sel_we;
      op_uns   <= sel_uns;
      op_size  <= sel_size;
      op_lo    <= sel_addr[1:0];
      op_wdata <= sel_wdata[15:0];
    end
  end

endmodule
